// File: rtl/fib_seq_stream.sv
// Fibonacci-style pair stepper with HOLD/STEP/LOAD/RESTART commands and a one-entry result register.
// Result appears one cycle after accept; a held result blocks new commands until the consumer takes it.
module fib_seq_stream #(
  parameter int WIDTH    = 8,
  parameter int SEED0    = 0,
  parameter int SEED1    = 1,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] ld_a,
  input  logic [WIDTH-1:0] ld_b,
  output logic             cmd_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ovf,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [1:0]       OP_HOLD    = 2'b00;
  localparam logic [1:0]       OP_STEP    = 2'b01;
  localparam logic [1:0]       OP_LOAD    = 2'b10;
  localparam logic [WIDTH-1:0] SEED0_W    = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] SEED1_W    = WIDTH'(SEED1);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   sum;

  assign cmd_ready = !vld_q || out_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign sum       = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    data_d = data_q;
    vld_d  = vld_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (accept) begin
      vld_d = 1'b1;
      case (cmd_op)
        OP_HOLD: begin
          data_d = a_q;
        end
        OP_STEP: begin
          a_d    = b_q;
          data_d = b_q;
          b_d    = sum[WIDTH-1:0];
          // Carry out of the pair sum is the overflow event.
          if (sum[WIDTH]) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) b_d = ALL_ONES;
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        OP_LOAD: begin
          a_d    = ld_a;
          b_d    = ld_b;
          data_d = ld_a;
          ovf_d  = 1'b0;
          cnt_d  = '0;
        end
        default: begin
          a_d    = SEED0_W;
          b_d    = SEED1_W;
          data_d = SEED0_W;
          ovf_d  = 1'b0;
          cnt_d  = '0;
        end
      endcase
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= SEED0_W;
      b_q    <= SEED1_W;
      data_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign ovf       = ovf_q;
  assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_fib_seq_stream.sv
// Bench for fib_seq_stream: three parameter variants (default, saturating, Lucas with 4-bit counter)
// share one stimulus stream and are compared each cycle against an arithmetic model.
module tb_fib_seq_stream;

  localparam logic [1:0] HOLD = 2'b00, STEP = 2'b01, LOAD = 2'b10, RESTART = 2'b11;

  logic       clk, rst;
  logic       cmd_valid, out_ready;
  logic [1:0] cmd_op;
  logic [7:0] ld_a, ld_b;

  logic       cr[3], ov[3], ovf[3];
  logic [7:0] od[3];
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  fib_seq_stream u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .ld_a(ld_a), .ld_b(ld_b),
    .cmd_ready(cr[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .ovf(ovf[0]), .step_cnt(cnt0));

  fib_seq_stream #(.SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .ld_a(ld_a), .ld_b(ld_b),
    .cmd_ready(cr[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .ovf(ovf[1]), .step_cnt(cnt1));

  fib_seq_stream #(.SEED0(2), .SEED1(1), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .ld_a(ld_a), .ld_b(ld_b),
    .cmd_ready(cr[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .ovf(ovf[2]), .step_cnt(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: plain integer arithmetic per variant.
  localparam int unsigned MAXV = 255;
  int unsigned s0[3]   = '{0, 0, 2};
  int unsigned s1[3]   = '{1, 1, 1};
  bit          satp[3] = '{0, 1, 0};
  int unsigned cmax[3] = '{65535, 65535, 15};

  int unsigned ma[3], mb[3], mod[3], mcnt[3];
  bit          mov[3], movf[3];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          ma[i] = s0[i]; mb[i] = s1[i]; mod[i] = 0; mov[i] = 0; movf[i] = 0; mcnt[i] = 0;
        end else if (cmd_valid && (!mov[i] || out_ready)) begin
          int unsigned s;
          mov[i] = 1;
          case (cmd_op)
            HOLD: mod[i] = ma[i];
            STEP: begin
              s = ma[i] + mb[i];
              mod[i] = mb[i];
              ma[i] = mb[i];
              if (s > MAXV) begin
                movf[i] = 1;
                mb[i] = satp[i] ? MAXV : s - (MAXV + 1);
              end else begin
                mb[i] = s;
              end
              if (mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
            end
            LOAD: begin
              ma[i] = ld_a; mb[i] = ld_b; mod[i] = ld_a; movf[i] = 0; mcnt[i] = 0;
            end
            default: begin
              ma[i] = s0[i]; mb[i] = s1[i]; mod[i] = s0[i]; movf[i] = 0; mcnt[i] = 0;
            end
          endcase
        end else if (out_ready) begin
          mov[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int unsigned c;
        c = (i == 0) ? cnt0 : (i == 1) ? cnt1 : {12'd0, cnt2};
        chk($sformatf("u%0d cmd_ready", i), cr[i], (!mov[i] || out_ready) ? 1 : 0);
        chk($sformatf("u%0d out_valid", i), ov[i], mov[i]);
        chk($sformatf("u%0d out_data", i), od[i], mod[i]);
        chk($sformatf("u%0d ovf", i), ovf[i], movf[i]);
        chk($sformatf("u%0d step_cnt", i), c, mcnt[i]);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1'b1; cmd_op = op; ld_a = a; ld_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  int unsigned fib_exp[14] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
  int unsigned luc_exp[5]  = '{1, 3, 4, 7, 11};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = HOLD; ld_a = 8'd0; ld_b = 8'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", ov[0], 0);
    chk("reset out_data", od[0], 0);
    chk("reset ovf", ovf[0], 0);
    chk("reset step_cnt", cnt0, 0);
    chk("reset cmd_ready", cr[0], 1);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) begin
      issue(STEP, 8'd0, 8'd0);
      chk($sformatf("fib step %0d", k + 1), od[0], fib_exp[k]);
      if (k < 5) chk($sformatf("lucas step %0d", k + 1), od[2], luc_exp[k]);
      if (k == 11) chk("ovf before wrap", ovf[0], 0);
      if (k == 12) begin
        chk("ovf at 13th step", ovf[0], 1);
        chk("sat ovf at 13th step", ovf[1], 1);
        chk("step_cnt after 13", cnt0, 13);
      end
    end
    chk("sat 14th out_data", od[1], 255);
    chk("step_cnt after 14", cnt0, 14);
    repeat (3) issue(STEP, 8'd0, 8'd0);
    chk("step_cnt after 17", cnt0, 17);
    chk("4-bit step_cnt saturates", cnt2, 15);

    issue(LOAD, 8'd200, 8'd100);
    chk("load out_data", od[0], 200);
    chk("load ovf clear", ovf[0], 0);
    chk("load step_cnt clear", cnt0, 0);
    issue(STEP, 8'd0, 8'd0);
    chk("post-load step out_data", od[0], 100);
    chk("post-load step ovf", ovf[0], 1);

    // Backpressure: one accepted STEP, then stall with the command held.
    issue(RESTART, 8'd0, 8'd0);
    @(posedge clk); #1;
    out_ready = 1'b0; cmd_valid = 1'b1; cmd_op = STEP;
    @(posedge clk); #1;
    chk("bp first result", od[0], 1);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk("bp cmd_ready low", cr[0], 0);
      chk("bp out_data stable", od[0], 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp resume 1", od[0], 1);
    chk("bp resume lucas", od[2], 3);
    @(posedge clk); #1;
    chk("bp resume 2", od[0], 2);
    cmd_valid = 1'b0;

    // Reset with a pending result.
    out_ready = 1'b0;
    issue(STEP, 8'd0, 8'd0);
    chk("pending before reset", ov[0], 1);
    rst = 1'b1;
    #1;
    chk("async reset drops out_valid", ov[0], 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    issue(HOLD, 8'd0, 8'd0);
    chk("hold after reset", od[0], 0);
    chk("lucas hold after reset", od[2], 2);
    issue(RESTART, 8'd0, 8'd0);
    chk("restart out_data", od[0], 0);
    chk("lucas restart out_data", od[2], 2);
    for (int k = 0; k < 5; k++) begin
      issue(STEP, 8'd0, 8'd0);
      chk($sformatf("lucas again %0d", k + 1), od[2], luc_exp[k]);
    end

    // Randomized traffic; the per-cycle comparison does the checking.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = (r < 6) ? STEP : (r == 7) ? LOAD : (r == 8) ? RESTART : HOLD;
      ld_a      = 8'($urandom_range(0, 255));
      ld_b      = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
